// File: rtl/counter_sequencer_pkg.sv
// Shared types and reset-time configuration for counter_sequencer.
// Optional down counting is enabled by COUNTER_SEQUENCER_DOWN_EN.
package counter_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_MIN      = 0;
    localparam logic [63:0] DEF_MAX      = '1;
    localparam int unsigned DEF_STEP     = 1;
    localparam int unsigned DEF_PRESCALE = 0;

endpackage

// File: rtl/counter_sequencer_prescaler.sv
// Clock divider: strobe is high on the cycle the count reaches divisor.
module counter_prescaler
    import counter_sequencer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 24
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] divisor,
    output logic                  strobe
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == divisor) ? '0 : cnt_q + PRESCALE_W'(1);
        end
    end

    // A clear cycle never produces a step.
    assign strobe = enable && !clear && (cnt_q == divisor);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Runtime-configurable prescaled bounded counter with start/stop sequencing.
// Define COUNTER_SEQUENCER_DOWN_EN to add the cfg_down port and down counting.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned PRESCALE_W = 24
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      cfg_min,
    input  logic [WIDTH-1:0]      cfg_max,
    input  logic [WIDTH-1:0]      cfg_step,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  cfg_oneshot,
`ifdef COUNTER_SEQUENCER_DOWN_EN
    input  logic                  cfg_down,
`endif
    input  logic                  start,
    input  logic                  stop,
    output logic [WIDTH-1:0]      count_out,
    output logic                  tick_out,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      min_q, min_d, max_q, max_d, step_q, step_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  oneshot_q, oneshot_d;
    logic                  tick_q, tick_d, done_q, done_d, err_q, err_d;
    logic                  busy_q, busy_d, ready_q, ready_d;
`ifdef COUNTER_SEQUENCER_DOWN_EN
    logic                  down_q, down_d;
    logic [WIDTH:0]        diff;
`endif
    logic                  cfg_acc, cfg_ok, go, halt, step_stb, over;
    logic [WIDTH:0]        sum;
    logic [WIDTH-1:0]      next_val, wrap_val, load_val;

    assign cfg_acc = cfg_valid && (state_q != RUN);
    assign cfg_ok  = cfg_acc && (cfg_min <= cfg_max);
    assign go      = (state_q != RUN) && start && !stop;
    assign halt    = (state_q == RUN) && stop;

    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clear   (go || halt),
        .enable  (state_q == RUN),
        .divisor (prescale_q),
        .strobe  (step_stb)
    );

    // Candidate step value, bound violation and start value; a same-cycle write feeds start.
    always_comb begin
        sum = {1'b0, count_q} + {1'b0, step_q};
`ifdef COUNTER_SEQUENCER_DOWN_EN
        diff = {1'b0, count_q} - {1'b0, step_q};
        if (down_q) begin
            next_val = diff[WIDTH-1:0];
            over     = diff[WIDTH] || (diff[WIDTH-1:0] < min_q);
            wrap_val = max_q;
        end else begin
            next_val = sum[WIDTH-1:0];
            over     = sum > {1'b0, max_q};
            wrap_val = min_q;
        end
        if (cfg_ok) begin
            load_val = cfg_down ? cfg_max : cfg_min;
        end else begin
            load_val = down_q ? max_q : min_q;
        end
`else
        next_val = sum[WIDTH-1:0];
        over     = sum > {1'b0, max_q};
        wrap_val = min_q;
        load_val = cfg_ok ? cfg_min : min_q;
`endif
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (go) state_d = RUN;
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (step_stb && over && oneshot_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        min_d      = min_q;
        max_d      = max_q;
        step_d     = step_q;
        prescale_d = prescale_q;
        oneshot_d  = oneshot_q;
`ifdef COUNTER_SEQUENCER_DOWN_EN
        down_d     = down_q;
`endif
        count_d    = count_q;
        err_d      = err_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        busy_d     = (state_d == RUN);
        ready_d    = (state_d != RUN);

        if (cfg_acc) begin
            err_d = !cfg_ok;
            if (cfg_ok) begin
                min_d      = cfg_min;
                max_d      = cfg_max;
                step_d     = cfg_step;
                prescale_d = cfg_prescale;
                oneshot_d  = cfg_oneshot;
`ifdef COUNTER_SEQUENCER_DOWN_EN
                down_d     = cfg_down;
`endif
            end
        end

        if (go) begin
            count_d = load_val;
        end else if ((state_q == RUN) && !stop && step_stb) begin
            tick_d = 1'b1;
            if (!over) begin
                count_d = next_val;
            end else if (!oneshot_q) begin
                count_d = wrap_val;
            end else begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            min_q      <= WIDTH'(DEF_MIN);
            max_q      <= WIDTH'(DEF_MAX);
            step_q     <= WIDTH'(DEF_STEP);
            prescale_q <= PRESCALE_W'(DEF_PRESCALE);
            oneshot_q  <= 1'b0;
`ifdef COUNTER_SEQUENCER_DOWN_EN
            down_q     <= 1'b0;
`endif
            count_q    <= '0;
            err_q      <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            min_q      <= min_d;
            max_q      <= max_d;
            step_q     <= step_d;
            prescale_q <= prescale_d;
            oneshot_q  <= oneshot_d;
`ifdef COUNTER_SEQUENCER_DOWN_EN
            down_q     <= down_d;
`endif
            count_q    <= count_d;
            err_q      <= err_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign cfg_ready = ready_q;
    assign count_out = count_q;
    assign tick_out  = tick_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: expected ticks are queued at start, a monitor pops them.
`timescale 1ns/1ps
module tb_counter_sequencer;

    localparam int unsigned W  = 4;
    localparam int unsigned PW = 24;
`ifdef COUNTER_SEQUENCER_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [W-1:0]  cfg_min = '0;
    logic [W-1:0]  cfg_max = '0;
    logic [W-1:0]  cfg_step = '0;
    logic [PW-1:0] cfg_prescale = '0;
    logic          cfg_oneshot = 1'b0;
    logic          req_down = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [W-1:0]  count_out;
    logic          tick_out, busy, done, cfg_err;

    counter_sequencer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_min      (cfg_min),
        .cfg_max      (cfg_max),
        .cfg_step     (cfg_step),
        .cfg_prescale (cfg_prescale),
        .cfg_oneshot  (cfg_oneshot),
`ifdef COUNTER_SEQUENCER_DOWN_EN
        .cfg_down     (req_down),
`endif
        .start        (start),
        .stop         (stop),
        .count_out    (count_out),
        .tick_out     (tick_out),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    int unsigned cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        int          val;
        bit          last;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference configuration and last known count.
    int m_min = 0, m_max = 15, m_step = 1, m_pre = 0, m_count = 0;
    bit m_one = 0, m_down = 0, m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_min = 0; m_max = 15; m_step = 1; m_pre = 0;
        m_one = 0; m_down = 0; m_err = 0; m_count = 0;
    endtask

    task automatic model_cfg(input int mn, input int mx, input int st, input int pr, input bit one);
        if (mn > mx) begin
            m_err = 1;
        end else begin
            m_min = mn; m_max = mx; m_step = st; m_pre = pr;
            m_one = one; m_down = DOWN_EN && req_down; m_err = 0;
        end
    endtask

    task automatic drive_cfg(input int mn, input int mx, input int st, input int pr,
                             input bit one, input bit dn);
        cfg_valid    = 1'b1;
        cfg_min      = W'(mn);
        cfg_max      = W'(mx);
        cfg_step     = W'(st);
        cfg_prescale = PW'(pr);
        cfg_oneshot  = one;
        req_down     = dn;
    endtask

    task automatic cfg_write(input int mn, input int mx, input int st, input int pr,
                             input bit one, input bit dn);
        @(negedge clk_in);
        drive_cfg(mn, mx, st, pr, one, dn);
        model_cfg(mn, mx, st, pr, one);
        @(negedge clk_in);
        cfg_valid = 1'b0;
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        chk("cfg_ready_idle", 32'(cfg_ready), 1);
    endtask

    // Start a run lasting len cycles, then stop; optionally write config with start or mid-run.
    task automatic start_run(input int unsigned len, input bit stop_too, input bit with_cfg,
                             input int mn, input int mx, input int st, input int pr,
                             input bit one, input bit dn, input bit mid_cfg);
        int unsigned e_edge, s_edge, k;
        int cur, nxt;
        bit last;
        exp_t e;
        @(negedge clk_in);
        start = 1'b1;
        stop  = stop_too;
        if (with_cfg) begin
            drive_cfg(mn, mx, st, pr, one, dn);
            model_cfg(mn, mx, st, pr, one);
        end
        e_edge = cyc + 1;
        s_edge = e_edge + len;
        if (!stop_too) begin
            cur = m_down ? m_max : m_min;
            last = 0;
            k = 1;
            while (!last && (e_edge + k * (m_pre + 1) < s_edge)) begin
                if (m_down) begin
                    nxt = cur - m_step;
                    if (nxt < m_min) begin
                        if (m_one) begin last = 1; nxt = cur; end
                        else nxt = m_max;
                    end
                end else begin
                    nxt = cur + m_step;
                    if (nxt > m_max) begin
                        if (m_one) begin last = 1; nxt = cur; end
                        else nxt = m_min;
                    end
                end
                e.cyc = e_edge + k * (m_pre + 1);
                e.val = nxt;
                e.last = last;
                q.push_back(e);
                cur = nxt;
                k++;
            end
            m_count = cur;
        end
        @(negedge clk_in);
        start = 1'b0;
        stop = 1'b0;
        cfg_valid = 1'b0;
        if (with_cfg) chk("cfg_err_with_start", 32'(cfg_err), 32'(m_err));
        if (stop_too) begin
            chk("start_stop_busy", 32'(busy), 0);
            chk("start_stop_count", 32'(count_out), m_count);
            return;
        end
        chk("run_busy", 32'(busy), 1);
        chk("run_ready", 32'(cfg_ready), 0);
        if (mid_cfg) drive_cfg($urandom_range(0, 7), $urandom_range(8, 15), $urandom_range(0, 5),
                               $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (len - 1) begin
            @(negedge clk_in);
            cfg_valid = 1'b0;
        end
        stop = 1'b1;
        @(negedge clk_in);
        stop = 1'b0;
        cfg_valid = 1'b0;
        chk("stop_busy", 32'(busy), 0);
        chk("stop_ready", 32'(cfg_ready), 1);
        chk("final_count", 32'(count_out), m_count);
        chk("queue_drained", q.size(), 0);
        q.delete();
    endtask

    // Monitor: every tick must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                if (tick_out) begin
                    if (q.size() == 0) begin
                        chk("unexpected_tick", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("tick_cycle", cyc, e.cyc);
                        chk("tick_count", 32'(count_out), e.val);
                        chk("tick_done", 32'(done), 32'(e.last));
                    end
                end else if (done) begin
                    chk("done_without_tick", 1, 0);
                end
            end
        end
    end

    initial begin
        int mn, mx;
        bit wc;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        chk("reset_count", 32'(count_out), 0);
        chk("reset_tick", 32'(tick_out), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_err", 32'(cfg_err), 0);
        chk("reset_ready", 32'(cfg_ready), 1);

        start_run(20, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cfg_write(3, 9, 2, 4, 1, 0);
        start_run(30, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cfg_write(10, 5, 1, 0, 0, 0);
        start_run(24, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cfg_write(0, 15, 2, 1, 0, 0);
        start_run(7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) @(negedge clk_in);
        chk("idle_hold_count", 32'(count_out), 6);
        start_run(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        start_run(12, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        start_run(15, 0, 1, 4, 12, 3, 2, 0, 0, 0);
        cfg_write(5, 5, 1, 0, 1, 0);
        start_run(4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cfg_write(2, 9, 0, 1, 1, 0);
        start_run(10, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a run.
        cfg_write(5, 15, 1, 20, 0, 0);
        @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("pre_reset_count", 32'(count_out), 5);
        #2 rst_in = 1'b1;
        #1;
        chk("async_reset_count", 32'(count_out), 0);
        chk("async_reset_busy", 32'(busy), 0);
        chk("async_reset_ready", 32'(cfg_ready), 1);
        q.delete();
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        start_run(18, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        if (DOWN_EN) begin
            cfg_write(2, 8, 3, 0, 0, 1);
            start_run(6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        for (int i = 0; i < 14; i++) begin
            mn = $urandom_range(0, 15);
            mx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(mn, 15));
            wc = ($urandom_range(0, 2) == 0);
            if (!wc) cfg_write(mn, mx, $urandom_range(0, 5), $urandom_range(0, 3),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            start_run($urandom_range(1, 40), ($urandom_range(0, 9) == 0), wc, mn, mx,
                      $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
